// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, PC/IF-ID stall and
// bubble insertion on hazard or branch/jump flush.
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic [XLEN-1:0]   rdata1_id,
    input  logic [XLEN-1:0]   rdata2_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [2:0]        funct3_id,
    input  logic              funct7b5_id,
    input  logic [7:0]        ctrl_id,
    input  logic              hold,
    input  logic              flush,
    output logic [6:0]        opcode_ex,
    output logic [REG_AW-1:0] rs1_ex,
    output logic [REG_AW-1:0] rs2_ex,
    output logic [REG_AW-1:0] rd_ex,
    output logic [XLEN-1:0]   rdata1_ex,
    output logic [XLEN-1:0]   rdata2_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [2:0]        funct3_ex,
    output logic              funct7b5_ex,
    output logic [7:0]        ctrl_ex,
    output logic              stall_if_id,
    output logic [15:0]       bubble_cnt
);

    localparam int CTRL_MEMREAD = 6;
    localparam int CTRL_VALID   = 0;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [7:0]        ctrl;
    } idex_t;

    idex_t       id_pkt;
    idex_t       pipe_d, pipe_q;
    logic [15:0] cnt_d, cnt_q;
    logic        use_rs1, use_rs2, hazard;

    assign id_pkt = '{opcode: opcode_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id,
                      rdata1: rdata1_id, rdata2: rdata2_id, imm: imm_id, pc: pc_id,
                      funct3: funct3_id, funct7b5: funct7b5_id, ctrl: ctrl_id};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode_id)
            OP_RTYPE, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // x0 as a load destination can never produce a real dependency
    assign hazard = pipe_q.ctrl[CTRL_MEMREAD] && pipe_q.ctrl[CTRL_VALID] &&
                    (pipe_q.rd != '0) && ctrl_id[CTRL_VALID] && !flush &&
                    ((use_rs1 && (pipe_q.rd == rs1_id)) ||
                     (use_rs2 && (pipe_q.rd == rs2_id)));

    assign stall_if_id = hazard || hold;

    always_comb begin
        pipe_d = pipe_q;
        cnt_d  = cnt_q;
        if (flush) begin
            pipe_d = '0;
        end else if (hold) begin
            pipe_d = pipe_q;
        end else if (hazard) begin
            pipe_d = '0;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else begin
            pipe_d = id_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    assign opcode_ex   = pipe_q.opcode;
    assign rs1_ex      = pipe_q.rs1;
    assign rs2_ex      = pipe_q.rs2;
    assign rd_ex       = pipe_q.rd;
    assign rdata1_ex   = pipe_q.rdata1;
    assign rdata2_ex   = pipe_q.rdata2;
    assign imm_ex      = pipe_q.imm;
    assign pc_ex       = pipe_q.pc;
    assign funct3_ex   = pipe_q.funct3;
    assign funct7b5_ex = pipe_q.funct7b5;
    assign ctrl_ex     = pipe_q.ctrl;
    assign bubble_cnt  = cnt_q;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection; sits between the decode stage and the execute stage.
- Latches decoded operands, register indices, immediate, PC and control bits each cycle.
- Supplies opcode_ex, rs1_ex and rs2_ex to the EX-stage forwarding logic.
- Detects load-use hazards, stalls PC and IF/ID, and inserts bubbles on hazard or branch/jump flush.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- REG_AW, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode_id  input  7  decoded opcode.
- rs1_id, rs2_id, rd_id  input  REG_AW  register indices from decode.
- rdata1_id, rdata2_id  input  XLEN  register file read data.
- imm_id  input  XLEN  sign-extended immediate.
- pc_id  input  XLEN  instruction PC.
- funct3_id  input  3  funct3 field.
- funct7b5_id  input  1  funct7 bit 5.
- ctrl_id  input  8  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, valid}.
- hold  input  1  global pipeline freeze (memory wait).
- flush  input  1  branch/jump redirect from EX.
- opcode_ex  output  7  registered opcode.
- rs1_ex, rs2_ex, rd_ex  output  REG_AW  registered indices.
- rdata1_ex, rdata2_ex, imm_ex, pc_ex  output  XLEN  registered data.
- funct3_ex  output  3  registered funct3.
- funct7b5_ex  output  1  registered funct7 bit 5.
- ctrl_ex  output  8  registered control, same bit order as ctrl_id.
- stall_if_id  output  1  combinational; holds PC and IF/ID when high.
- bubble_cnt  output  16  saturating count of hazard bubbles inserted.

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs go to 0, including bubble_cnt. A zero opcode_ex and zero ctrl_ex together form a NOP. Reset takes effect immediately, including mid-stall.
- Operand usage (for rs1_id and rs2_id):
  - Opcodes 0110011, 0100011, 1100011 use rs1 and rs2.
  - Opcodes 0000011, 0010011, 1100111 use rs1 only.
  - All other opcodes use neither.
- Hazard (combinational): asserted when all of the following hold:
  - ctrl_ex.MemRead = 1 and ctrl_ex.valid = 1;
  - rd_ex != 0;
  - rd_ex equals a used rs of the ID instruction;
  - ctrl_id.valid = 1;
  - flush = 0.
- stall_if_id = hazard OR hold.
- Per-edge update priority (highest first):
  1. flush: load a bubble. opcode_ex = 0, ctrl_ex = 0, all other fields = 0. Flush wins over hold.
  2. hold: every field retains its value.
  3. hazard: load a bubble as in flush; bubble_cnt increments (saturating at 16'hFFFF).
  4. Otherwise: capture all *_id inputs.
- Latency: exactly one cycle from ID inputs to EX outputs when no stall.
- Back-to-back load-use:
  - Hazard lasts exactly one cycle, because the inserted bubble clears MemRead.
  - On the next edge the ID instruction enters normally. The forwarding logic then handles the WB-distance dependency.
- Bubble: ctrl_ex bit RegWrite = 0, so a bubble is never a forwarding source.
- x0 destination never triggers a hazard.
- hazard and flush together: flush wins; no bubble count increment.

Test Plan:
- Reset mid-stream: drive valid instr, assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, bubble_cnt=0.
- Plain pass-through: opcode_id=0110011, rs1=3, rs2=4, rd=5, rdata1=32'h11, imm=0 -> next edge outputs equal inputs; stall_if_id=0.
- Load-use:
  - Stimulus: lw x6 in EX (MemRead=1, rd_ex=6); ID add with rs2_id=6.
  - Required: stall_if_id=1 that cycle; next edge ctrl_ex=0, bubble_cnt=1.
  - Following cycle: stall_if_id=0 and the add is captured.
- Non-hazards, each -> stall_if_id=0:
  - lw rd_ex=0 with ID rs1=0;
  - lw rd_ex=7 with ID addi rs2 field=7 (rs2 unused);
  - lw rd_ex=7 with ID lui.
- Flush priority: hazard condition plus flush=1 plus hold=1 -> stall_if_id=0 from hazard (hold still drives 1); next edge bubble, bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles with changing ID inputs -> EX outputs frozen; release -> current ID inputs captured next edge.
